// File: rtl/pacman_input_pkg.sv
// Shared types and constants for the Pac-Man input conditioning stage.
package pacman_input_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, WAIT_REL} coin_state_t;

  // Set-2 make codes; arrows are matched with or without the E0 prefix
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_CTRL  = 8'h14;
  localparam logic [7:0] SC_F1    = 8'h05;
  localparam logic [7:0] SC_1     = 8'h16;
  localparam logic [7:0] SC_F2    = 8'h06;
  localparam logic [7:0] SC_2     = 8'h1E;
  localparam logic [7:0] SC_F3    = 8'h04;
  localparam logic [7:0] SC_5     = 8'h2E;
  localparam logic [7:0] SC_6     = 8'h36;
  localparam logic [7:0] SC_F4    = 8'h0C;
  localparam logic [7:0] SC_R     = 8'h2D;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_G     = 8'h34;
  localparam logic [7:0] SC_A     = 8'h1C;

  localparam int DIR_R = 0;
  localparam int DIR_L = 1;
  localparam int DIR_D = 2;
  localparam int DIR_U = 3;

  localparam int JB_FIRE   = 4;
  localparam int JB_START1 = 5;
  localparam int JB_START2 = 6;
  localparam int JB_COIN   = 7;
  localparam int JB_CHEAT  = 8;

  // One-hot of the highest set direction bit (up beats down beats left beats right)
  function automatic logic [3:0] onehot_hi(input logic [3:0] v);
    logic [3:0] r;
    r = 4'd0;
    if (v[DIR_U])      r[DIR_U] = 1'b1;
    else if (v[DIR_D]) r[DIR_D] = 1'b1;
    else if (v[DIR_L]) r[DIR_L] = 1'b1;
    else if (v[DIR_R]) r[DIR_R] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/pacman_fourway.sv
// 4-way stick filter: the most recent new press owns the stick until it is released.
// indir is registered here (in1); outdir is registered, so input to output is 2 cycles.
module pacman_fourway
  import pacman_input_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       dis,
  input  logic [3:0] indir,
  output logic [3:0] outdir
);

  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] mask;
  logic [3:0] mask_nxt;
  logic [3:0] newpress;

  assign newpress = in1 & ~in2;

  // Losing the owning direction reopens the stick, even if a new press lands that cycle
  always_comb begin
    mask_nxt = mask;
    if (dis || ((in1 & mask) == 4'd0)) begin
      mask_nxt = 4'hF;
    end else if (newpress != 4'd0) begin
      mask_nxt = onehot_hi(newpress);
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      in1    <= 4'd0;
      in2    <= 4'd0;
      mask   <= 4'hF;
      outdir <= 4'd0;
    end else begin
      in1    <= indir;
      in2    <= in1;
      mask   <= mask_nxt;
      outdir <= in1 & mask_nxt;
    end
  end

endmodule

// File: rtl/pacman_input_ctrl.sv
// Merges PS/2 keys and two joysticks into per-player Pac-Man controls with 4-way filtering and a timed coin pulse.
// Optional autofire (adds input af_en) is built when PACMAN_INPUT_AUTOFIRE_EN is defined.
module pacman_input_ctrl
  import pacman_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd60000,
  parameter logic [16:0] COIN_GAP   = 17'd120000,
  parameter logic [19:0] AF_PERIOD  = 20'd400000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy1,
  input  logic [15:0] joy2,
  input  logic        share_players,
  input  logic        fourway_dis,
`ifdef PACMAN_INPUT_AUTOFIRE_EN
  input  logic        af_en,
`endif
  output logic [3:0]  p1_dir,
  output logic [3:0]  p2_dir,
  output logic        fire1,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        cheat,
  output logic        coin,
  output logic [7:0]  coin_count
);

  localparam logic [16:0] PULSE_LD = {1'b0, COIN_PULSE} - 17'd1;
  localparam logic [16:0] GAP_LD   = COIN_GAP - 17'd1;

  logic       ps2_stb_d;
  logic       ps2_evt;
  logic       pressed;
  logic       ext;
  logic [7:0] sc;
  logic [3:0] key_p1;
  logic [3:0] key_p2;
  logic       key_fire1;
  logic       key_fire2;
  logic       key_start1;
  logic       key_start2;
  logic       key_coin;
  logic       key_cheat;

  assign pressed = ps2_key[9];
  assign ext     = ps2_key[8];
  assign sc      = ps2_key[7:0];
  assign ps2_evt = ps2_stb_d != ps2_key[10];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ps2_stb_d  <= 1'b0;
      key_p1     <= 4'd0;
      key_p2     <= 4'd0;
      key_fire1  <= 1'b0;
      key_fire2  <= 1'b0;
      key_start1 <= 1'b0;
      key_start2 <= 1'b0;
      key_coin   <= 1'b0;
      key_cheat  <= 1'b0;
    end else begin
      ps2_stb_d <= ps2_key[10];
      if (ps2_evt) begin
        case (sc)
          SC_UP:    key_p1[DIR_U] <= pressed;
          SC_DOWN:  key_p1[DIR_D] <= pressed;
          SC_LEFT:  key_p1[DIR_L] <= pressed;
          SC_RIGHT: key_p1[DIR_R] <= pressed;
          default:  ;
        endcase
        if (!ext) begin
          case (sc)
            SC_SPACE, SC_CTRL: key_fire1  <= pressed;
            SC_F1, SC_1:       key_start1 <= pressed;
            SC_F2, SC_2:       key_start2 <= pressed;
            SC_F3, SC_5, SC_6: key_coin   <= pressed;
            SC_F4:             key_cheat  <= pressed;
            SC_R:              key_p2[DIR_U] <= pressed;
            SC_F:              key_p2[DIR_D] <= pressed;
            SC_D:              key_p2[DIR_L] <= pressed;
            SC_G:              key_p2[DIR_R] <= pressed;
            SC_A:              key_fire2  <= pressed;
            default:           ;
          endcase
        end
      end
    end
  end

  logic [4:0] ja;
  logic [4:0] jb;
  logic [3:0] raw_p1;
  logic [3:0] raw_p2;

  assign ja     = share_players ? (joy1[4:0] | joy2[4:0]) : joy1[4:0];
  assign jb     = share_players ? (joy1[4:0] | joy2[4:0]) : joy2[4:0];
  assign raw_p1 = key_p1 | ja[3:0];
  assign raw_p2 = key_p2 | jb[3:0];

  pacman_fourway u_fourway_p1 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .dis     (fourway_dis),
    .indir   (raw_p1),
    .outdir  (p1_dir)
  );

  pacman_fourway u_fourway_p2 (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .dis     (fourway_dis),
    .indir   (raw_p2),
    .outdir  (p2_dir)
  );

  logic [1:0] fire_in1;
  logic       start1_in1;
  logic       start2_in1;
  logic       cheat_in1;
  logic       coin_req;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fire_in1   <= 2'd0;
      start1_in1 <= 1'b0;
      start2_in1 <= 1'b0;
      cheat_in1  <= 1'b0;
      coin_req   <= 1'b0;
      start1     <= 1'b0;
      start2     <= 1'b0;
      cheat      <= 1'b0;
    end else begin
      fire_in1   <= {key_fire2 | jb[JB_FIRE], key_fire1 | ja[JB_FIRE]};
      start1_in1 <= key_start1 | joy1[JB_START1] | joy2[JB_START1];
      start2_in1 <= key_start2 | joy1[JB_START2] | joy2[JB_START2];
      cheat_in1  <= key_cheat | joy1[JB_CHEAT] | joy2[JB_CHEAT];
      coin_req   <= key_coin | joy1[JB_COIN] | joy2[JB_COIN];
      start1     <= start1_in1;
      start2     <= start2_in1;
      cheat      <= cheat_in1;
    end
  end

  logic [1:0] fire_q;

`ifdef PACMAN_INPUT_AUTOFIRE_EN
  logic [1:0][19:0] af_cnt;
  logic [1:0]       af_phase;

  // Phase 0 drives fire high, so a fresh press fires immediately
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      af_cnt   <= '0;
      af_phase <= 2'd0;
      fire_q   <= 2'd0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!fire_in1[i] || !af_en) begin
          af_cnt[i]   <= 20'd0;
          af_phase[i] <= 1'b0;
        end else if (af_cnt[i] == AF_PERIOD - 20'd1) begin
          af_cnt[i]   <= 20'd0;
          af_phase[i] <= ~af_phase[i];
        end else begin
          af_cnt[i]   <= af_cnt[i] + 20'd1;
        end
        fire_q[i] <= fire_in1[i] & ~(af_en & af_phase[i]);
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{joy1[15:9], joy2[15:9]};
`else
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      fire_q <= 2'd0;
    end else begin
      fire_q <= fire_in1;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{joy1[15:9], joy2[15:9], AF_PERIOD};
`endif

  assign fire1 = fire_q[0];
  assign fire2 = fire_q[1];

  coin_state_t state;
  coin_state_t state_nxt;
  logic [16:0] cnt;
  logic [16:0] cnt_nxt;
  logic [7:0]  count_nxt;
  logic        coin_req_d;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    count_nxt = coin_count;
    case (state)
      IDLE: begin
        if (coin_req && !coin_req_d) begin
          state_nxt = PULSE;
          cnt_nxt   = PULSE_LD;
          if (coin_count != 8'hFF) count_nxt = coin_count + 8'd1;
        end
      end
      PULSE: begin
        if (cnt == 17'd0) begin
          if (COIN_GAP == 17'd0) begin
            state_nxt = WAIT_REL;
          end else begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
          end
        end else begin
          cnt_nxt = cnt - 17'd1;
        end
      end
      GAP: begin
        if (cnt == 17'd0) state_nxt = WAIT_REL;
        else              cnt_nxt   = cnt - 17'd1;
      end
      WAIT_REL: begin
        if (!coin_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= 17'd0;
      coin_req_d <= 1'b0;
      coin_count <= 8'd0;
      coin       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      coin_req_d <= coin_req;
      coin_count <= count_nxt;
      coin       <= (state_nxt == PULSE);
    end
  end

endmodule

// File: tb/tb_pacman_input_ctrl.sv
// Directed bench for pacman_input_ctrl with short coin timing; autofire checks build with PACMAN_INPUT_AUTOFIRE_EN.
module tb_pacman_input_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = 11'd0;
  logic [15:0] joy1 = 16'd0;
  logic [15:0] joy2 = 16'd0;
  logic        share_players = 1'b0;
  logic        fourway_dis = 1'b0;
`ifdef PACMAN_INPUT_AUTOFIRE_EN
  logic        af_en = 1'b0;
`endif
  logic [3:0]  p1_dir;
  logic [3:0]  p2_dir;
  logic        fire1;
  logic        fire2;
  logic        start1;
  logic        start2;
  logic        cheat;
  logic        coin;
  logic [7:0]  coin_count;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk_sys = ~clk_sys;

  pacman_input_ctrl #(
    .COIN_PULSE (16'd4),
    .COIN_GAP   (17'd3),
    .AF_PERIOD  (20'd5)
  ) dut (
    .clk_sys       (clk_sys),
    .reset_n       (reset_n),
    .ps2_key       (ps2_key),
    .joy1          (joy1),
    .joy2          (joy2),
    .share_players (share_players),
    .fourway_dis   (fourway_dis),
`ifdef PACMAN_INPUT_AUTOFIRE_EN
    .af_en         (af_en),
`endif
    .p1_dir        (p1_dir),
    .p2_dir        (p2_dir),
    .fire1         (fire1),
    .fire2         (fire2),
    .start1        (start1),
    .start2        (start2),
    .cheat         (cheat),
    .coin          (coin),
    .coin_count    (coin_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic ps2_send(input logic pr, input logic ex, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pr, ex, code};
    tick(4);
  endtask

  initial begin
    int hi;
    int first;

    // Reset and idle
    tick(2);
    check("rst_dirs", 32'({p1_dir, p2_dir}), 32'h0);
    check("rst_coin", 32'(coin), 32'd0);
    check("rst_count", 32'(coin_count), 32'd0);
    reset_n = 1'b1;
    tick(3);
    check("idle_outs", 32'({p1_dir, p2_dir, fire1, fire2, start1, start2, cheat, coin}), 32'h0);
    check("idle_count", 32'(coin_count), 32'd0);

    // Two-cycle latency on P1 up
    joy1[3] = 1'b1;
    tick(1);
    check("up_lat1", 32'(p1_dir), 32'h0);
    tick(1);
    check("up_lat2", 32'(p1_dir), 32'h8);
    check("up_p2", 32'(p2_dir), 32'h0);
    joy1 = 16'd0;
    tick(4);

    // Shared players: joy2 right reaches both
    share_players = 1'b1;
    joy2[0] = 1'b1;
    tick(3);
    check("share_dirs", 32'({p1_dir, p2_dir}), 32'h11);
    joy2 = 16'd0;
    share_players = 1'b0;
    tick(4);

    // Per-player fire, shared start2/cheat
    joy2[4] = 1'b1;
    joy2[6] = 1'b1;
    joy2[8] = 1'b1;
    tick(3);
    check("fire_split", 32'({fire1, fire2, start1, start2, cheat}), 32'b01011);
    joy2 = 16'd0;
    tick(4);

    // 4-way: left, then add up, release up, then bypass
    joy1[1] = 1'b1;
    tick(3);
    check("fw_left", 32'(p1_dir), 32'h2);
    tick(7);
    joy1[3] = 1'b1;
    tick(3);
    check("fw_up_wins", 32'(p1_dir), 32'h8);
    joy1[3] = 1'b0;
    tick(3);
    check("fw_back_left", 32'(p1_dir), 32'h2);
    fourway_dis = 1'b1;
    joy1[3] = 1'b1;
    tick(3);
    check("fw_bypass", 32'(p1_dir), 32'hA);
    joy1 = 16'd0;
    fourway_dis = 1'b0;
    tick(4);

    // PS/2 decode
    ps2_send(1'b1, 1'b0, 8'h05);
    check("ps2_f1_press", 32'(start1), 32'd1);
    ps2_send(1'b0, 1'b0, 8'h05);
    check("ps2_f1_release", 32'(start1), 32'd0);
    ps2_send(1'b1, 1'b1, 8'h05);
    check("ps2_f1_ext_ignored", 32'(start1), 32'd0);
    ps2_send(1'b1, 1'b1, 8'h75);
    check("ps2_ext_up", 32'(p1_dir), 32'h8);
    ps2_send(1'b1, 1'b0, 8'h11);
    check("ps2_unmapped", 32'({p1_dir, p2_dir, fire1, fire2, start1, start2, cheat, coin}), 32'h2000);
    ps2_send(1'b1, 1'b0, 8'h2D);
    check("ps2_p2_up", 32'(p2_dir), 32'h8);
    ps2_send(1'b1, 1'b0, 8'h0C);
    check("ps2_cheat", 32'(cheat), 32'd1);
    ps2_send(1'b0, 1'b1, 8'h75);
    ps2_send(1'b0, 1'b0, 8'h2D);
    ps2_send(1'b0, 1'b0, 8'h0C);
    check("ps2_all_released", 32'({p1_dir, p2_dir, cheat}), 32'h0);

    // Held coin: one 4-cycle pulse starting 2 cycles after the press
    joy1[7] = 1'b1;
    hi = 0;
    first = 0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      if (coin) begin
        hi++;
        if (first == 0) first = i;
      end
    end
    check("coin_first", 32'(first), 32'd2);
    check("coin_high", 32'(hi), 32'd4);
    check("coin_count1", 32'(coin_count), 32'd1);
    joy1[7] = 1'b0;
    tick(6);

    // Re-press during the gap is ignored
    joy1[7] = 1'b1;
    hi = 0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) joy1[7] = 1'b0;
      if (i == 7) joy1[7] = 1'b1;
      tick(1);
      if (coin) hi++;
    end
    check("gap_high", 32'(hi), 32'd4);
    check("gap_count", 32'(coin_count), 32'd2);
    joy1[7] = 1'b0;
    tick(6);

    // Reset mid-pulse
    joy1[7] = 1'b1;
    tick(3);
    check("pulse_before_rst", 32'(coin), 32'd1);
    check("count3", 32'(coin_count), 32'd3);
    reset_n = 1'b0;
    #1;
    check("rst_async_coin", 32'(coin), 32'd0);
    check("rst_async_count", 32'(coin_count), 32'd0);
    joy1[7] = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(3);
    check("post_rst_idle", 32'(coin), 32'd0);

    // Saturation at 255
    for (int i = 0; i < 256; i++) begin
      joy1[7] = 1'b1;
      tick(1);
      joy1[7] = 1'b0;
      tick(11);
      if (i == 0) check("sat_first", 32'(coin_count), 32'd1);
      if (i == 254) check("sat_255", 32'(coin_count), 32'd255);
    end
    check("sat_hold", 32'(coin_count), 32'd255);

`ifdef PACMAN_INPUT_AUTOFIRE_EN
    // Autofire: 5 high, 5 low, from the second cycle after the press
    af_en = 1'b1;
    joy1[4] = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      tick(1);
      check("af_wave", 32'(fire1), 32'((i >= 2) && ((((i - 2) / 5) % 2) == 0)));
    end
    joy1[4] = 1'b0;
    tick(3);
    check("af_release", 32'(fire1), 32'd0);
    af_en = 1'b0;
    joy1[4] = 1'b1;
    tick(13);
    check("af_off_steady", 32'(fire1), 32'd1);
    joy1[4] = 1'b0;
    tick(3);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
